// File: rtl/sdram_port_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_port_sched : round-robin write/read burst scheduler for an SDRAM
//                    controller, managing circular buffer address pointers.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sdram_port_sched #(
  parameter logic [9:0]  BURST_LEN   = 10'd256,
  parameter logic [23:0] ADDR_MIN    = 24'd0,
  parameter logic [23:0] ADDR_MAX    = 24'd1023,
  parameter logic [10:0] RFIFO_DEPTH = 11'd1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_end,
  input  logic [10:0] wfifo_cnt,
  input  logic [10:0] rfifo_cnt,
  input  logic        rd_enable,
  input  logic        wr_addr_clr,
  input  logic        rd_addr_clr,
  input  logic        wr_ack,
  input  logic        rd_ack,
  output logic        wr_req,
  output logic [23:0] wr_addr,
  output logic [9:0]  wr_burst_len,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [9:0]  rd_burst_len,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        wr_req_q, wr_req_d;
  logic        rd_req_q, rd_req_d;
  logic        busy_q, busy_d;
  logic [23:0] wr_addr_q, wr_addr_d;
  logic [23:0] rd_addr_q, rd_addr_d;
  logic [9:0]  wr_cnt_q, wr_cnt_d;
  logic [9:0]  rd_cnt_q, rd_cnt_d;
  logic        wr_clr_pend_q, wr_clr_pend_d;
  logic        rd_clr_pend_q, rd_clr_pend_d;
  logic        rd_last_q, rd_last_d;

  logic        wr_elig, rd_elig;
  logic [9:0]  wr_cnt_inc, rd_cnt_inc;

  function automatic logic [23:0] next_addr(input logic [23:0] a);
    logic [24:0] n;
    n = {1'b0, a} + {15'd0, BURST_LEN};
    if (n > {1'b0, ADDR_MAX}) return ADDR_MIN;
    return n[23:0];
  endfunction

  // Free space compared in 12 bits so an overfull read FIFO never looks eligible
  assign wr_elig    = (wfifo_cnt >= {1'b0, BURST_LEN});
  assign rd_elig    = rd_enable &&
                      (({1'b0, rfifo_cnt} + {2'b0, BURST_LEN}) <= {1'b0, RFIFO_DEPTH});
  assign wr_cnt_inc = wr_cnt_q + 10'd1;
  assign rd_cnt_inc = rd_cnt_q + 10'd1;

  always_comb begin
    state_d       = state_q;
    wr_req_d      = wr_req_q;
    rd_req_d      = rd_req_q;
    busy_d        = busy_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    wr_clr_pend_d = wr_clr_pend_q;
    rd_clr_pend_d = rd_clr_pend_q;
    rd_last_d     = rd_last_q;

    // A clear arriving mid-burst is held until the burst completes
    if (wr_addr_clr) begin
      if (state_q == WRITE) wr_clr_pend_d = 1'b1;
      else                  wr_addr_d     = ADDR_MIN;
    end
    if (rd_addr_clr) begin
      if (state_q == READ) rd_clr_pend_d = 1'b1;
      else                 rd_addr_d     = ADDR_MIN;
    end

    case (state_q)
      IDLE: begin
        if (init_end) state_d = ARB;
      end
      ARB: begin
        if (wr_elig && (!rd_elig || rd_last_q)) begin
          state_d   = WRITE;
          wr_req_d  = 1'b1;
          busy_d    = 1'b1;
          rd_last_d = 1'b0;
        end else if (rd_elig) begin
          state_d   = READ;
          rd_req_d  = 1'b1;
          busy_d    = 1'b1;
          rd_last_d = 1'b1;
        end
      end
      WRITE: begin
        if (wr_ack) begin
          wr_cnt_d = wr_cnt_inc;
          if (wr_cnt_inc == BURST_LEN) begin
            wr_cnt_d      = 10'd0;
            wr_req_d      = 1'b0;
            busy_d        = 1'b0;
            state_d       = ARB;
            wr_addr_d     = (wr_clr_pend_q || wr_addr_clr) ? ADDR_MIN : next_addr(wr_addr_q);
            wr_clr_pend_d = 1'b0;
          end
        end
      end
      READ: begin
        if (rd_ack) begin
          rd_cnt_d = rd_cnt_inc;
          if (rd_cnt_inc == BURST_LEN) begin
            rd_cnt_d      = 10'd0;
            rd_req_d      = 1'b0;
            busy_d        = 1'b0;
            state_d       = ARB;
            rd_addr_d     = (rd_clr_pend_q || rd_addr_clr) ? ADDR_MIN : next_addr(rd_addr_q);
            rd_clr_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rd_last_q resets high so that the first tie goes to the write side
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      busy_q        <= 1'b0;
      wr_addr_q     <= ADDR_MIN;
      rd_addr_q     <= ADDR_MIN;
      wr_cnt_q      <= 10'd0;
      rd_cnt_q      <= 10'd0;
      wr_clr_pend_q <= 1'b0;
      rd_clr_pend_q <= 1'b0;
      rd_last_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_req_q      <= wr_req_d;
      rd_req_q      <= rd_req_d;
      busy_q        <= busy_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_clr_pend_q <= wr_clr_pend_d;
      rd_clr_pend_q <= rd_clr_pend_d;
      rd_last_q     <= rd_last_d;
    end
  end

  assign wr_req       = wr_req_q;
  assign rd_req       = rd_req_q;
  assign busy         = busy_q;
  assign wr_addr      = wr_addr_q;
  assign rd_addr      = rd_addr_q;
  assign wr_burst_len = BURST_LEN;
  assign rd_burst_len = BURST_LEN;

endmodule
`default_nettype wire
